// File: rtl/ps2_host_tx_pkg.sv
// ps2_pkg: state encoding, frame length and default timing for the PS/2 host transmitter
package ps2_pkg;
    typedef enum logic [2:0] {IDLE, INHIBIT, REQ, SEND, ACK, WAIT_IDLE, ERR} ps2_state_e;
    localparam int FRAME_LEN = 11;
    localparam int CNT_W = 20;
    localparam int INHIBIT_CYCLES_DEF = 5000;
    localparam int REQ_CYCLES_DEF = 20;
    localparam int FILTER_LEN_DEF = 8;
    localparam int TIMEOUT_CYCLES_DEF = 750000;
    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction
endpackage

// File: rtl/ps2_host_tx_if.sv
// ps2_host_tx_if: byte handshake between the keyboard controller and the PS/2 transmitter
interface ps2_host_tx_if;
    logic [7:0] tx_data;
    logic tx_valid;
    logic tx_ready;
    logic tx_done;
    logic tx_error;
    logic rx_inhibit;
    modport master (output tx_data, tx_valid, input tx_ready, tx_done, tx_error, rx_inhibit);
    modport slave (input tx_data, tx_valid, output tx_ready, tx_done, tx_error, rx_inhibit);
endinterface

// File: rtl/ps2_line_filter.sv
// ps2_line_filter: 2-FF synchronizer, FILTER_LEN glitch filter and falling-edge strobe for one PS/2 line
module ps2_line_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk50mhz,
    input  logic reset_n,
    input  logic pad_in,
    output logic level,
    output logic fall
);
    localparam int CW = $clog2(FILTER_LEN + 1);
    logic [1:0] sync;
    logic [CW-1:0] run;
    logic flip;
    // run counts consecutive samples disagreeing with the accepted level
    assign flip = (sync[1] != level) && (run == CW'(FILTER_LEN - 1));
    always_ff @(posedge clk50mhz or negedge reset_n)
        if (!reset_n) begin
            sync <= 2'b11;
            run <= '0;
            level <= 1'b1;
            fall <= 1'b0;
        end else begin
            sync <= {sync[0], pad_in};
            run <= (sync[1] == level || flip) ? '0 : run + 1'b1;
            level <= flip ? sync[1] : level;
            fall <= flip && !sync[1];
        end
endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device byte transmitter; define PS2_HOST_TX_TIMEOUT_EN for the watchdog
module ps2_host_tx import ps2_pkg::*; #(
    parameter int INHIBIT_CYCLES = INHIBIT_CYCLES_DEF,
    parameter int REQ_CYCLES = REQ_CYCLES_DEF,
    parameter int FILTER_LEN = FILTER_LEN_DEF
`ifdef PS2_HOST_TX_TIMEOUT_EN
    , parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
`endif
) (
    input  logic         clk50mhz,
    input  logic         reset_n,
    ps2_host_tx_if.slave bus,
    input  logic         ps2_clk_in,
    input  logic         ps2_dat_in,
    output logic         ps2_clk_oe,
    output logic         ps2_dat_oe
);
    ps2_state_e state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic [3:0] bit_cnt, bit_d;
    logic [9:0] frame, frame_d;
    logic clk_oe_d, dat_oe_d, ready_d, done_d, err_d, inh_d;
    logic clk_f, clk_fall, dat_f, dat_fall_unused;
    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk (
        .clk50mhz(clk50mhz), .reset_n(reset_n), .pad_in(ps2_clk_in), .level(clk_f), .fall(clk_fall));
    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_dat (
        .clk50mhz(clk50mhz), .reset_n(reset_n), .pad_in(ps2_dat_in), .level(dat_f), .fall(dat_fall_unused));
    always_comb begin
        state_d = state;
        cnt_d = cnt;
        bit_d = bit_cnt;
        frame_d = frame;
        clk_oe_d = ps2_clk_oe;
        dat_oe_d = ps2_dat_oe;
        ready_d = bus.tx_ready;
        inh_d = bus.rx_inhibit;
        done_d = 1'b0;
        err_d = 1'b0;
        unique case (state)
            IDLE: if (bus.tx_valid && bus.tx_ready) begin
                state_d = INHIBIT;
                cnt_d = '0;
                frame_d = {1'b1, odd_parity(bus.tx_data), bus.tx_data};
                clk_oe_d = 1'b1;
                ready_d = 1'b0;
                inh_d = 1'b1;
            end
            INHIBIT: begin
                cnt_d = cnt + 1'b1;
                if (cnt == CNT_W'(INHIBIT_CYCLES - 1)) begin
                    state_d = REQ;
                    cnt_d = '0;
                    dat_oe_d = 1'b1;
                end
            end
            REQ: begin
                cnt_d = cnt + 1'b1;
                if (cnt == CNT_W'(REQ_CYCLES - 1)) begin
                    state_d = SEND;
                    cnt_d = '0;
                    bit_d = '0;
                    clk_oe_d = 1'b0;
                end
            end
            // edge n presents frame bit n-1: data 0..7, parity, then the released stop bit
            SEND: if (clk_fall) begin
                bit_d = bit_cnt + 1'b1;
                dat_oe_d = ~frame[bit_cnt];
                state_d = (bit_d == 4'(FRAME_LEN - 1)) ? ACK : SEND;
            end
            ACK: if (clk_fall) begin
                bit_d = bit_cnt + 1'b1;
                state_d = dat_f ? ERR : WAIT_IDLE;
            end
            WAIT_IDLE: if (clk_f && dat_f) begin
                state_d = IDLE;
                done_d = 1'b1;
                ready_d = 1'b1;
                inh_d = 1'b0;
            end
            ERR: begin
                state_d = IDLE;
                err_d = 1'b1;
                ready_d = 1'b1;
                inh_d = 1'b0;
                clk_oe_d = 1'b0;
                dat_oe_d = 1'b0;
            end
            default: state_d = IDLE;
        endcase
`ifdef PS2_HOST_TX_TIMEOUT_EN
        // the shared counter becomes the watchdog once the device owns the clock
        if (state == SEND || state == ACK || state == WAIT_IDLE) begin
            cnt_d = clk_fall ? '0 : cnt + 1'b1;
            if (!clk_fall && !done_d && cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                state_d = ERR;
                clk_oe_d = 1'b0;
                dat_oe_d = 1'b0;
            end
        end
`endif
    end
    always_ff @(posedge clk50mhz or negedge reset_n)
        if (!reset_n) begin
            state <= IDLE;
            cnt <= '0;
            bit_cnt <= '0;
            frame <= '0;
            ps2_clk_oe <= 1'b0;
            ps2_dat_oe <= 1'b0;
            bus.tx_ready <= 1'b1;
            bus.tx_done <= 1'b0;
            bus.tx_error <= 1'b0;
            bus.rx_inhibit <= 1'b0;
        end else begin
            state <= state_d;
            cnt <= cnt_d;
            bit_cnt <= bit_d;
            frame <= frame_d;
            ps2_clk_oe <= clk_oe_d;
            ps2_dat_oe <= dat_oe_d;
            bus.tx_ready <= ready_d;
            bus.tx_done <= done_d;
            bus.tx_error <= err_d;
            bus.rx_inhibit <= inh_d;
        end
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: PS/2 device model plus frame-level reference model for ps2_host_tx
module tb_ps2_host_tx;
    localparam int INH = 300;
    localparam int REQ_C = 20;
    localparam int FLT = 8;
    localparam int TOUT = 4000;
    localparam int H = 60;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic dev_clk = 1'b1, dev_dat = 1'b1, glitch = 1'b0;
    logic clk_oe, dat_oe, pad_clk, pad_dat;
    logic [10:0] got;
    int passed = 0, total = 0, n_done = 0, n_err = 0, cyc = 0, last_fall = 0, e0;
    bit m_idle = 1'b1;
    int m_t = 0;
    ps2_host_tx_if bus();
    assign pad_clk = dev_clk & ~glitch & ~clk_oe;
    assign pad_dat = dev_dat & ~dat_oe;
    ps2_host_tx #(.INHIBIT_CYCLES(INH), .REQ_CYCLES(REQ_C), .FILTER_LEN(FLT)
`ifdef PS2_HOST_TX_TIMEOUT_EN
        , .TIMEOUT_CYCLES(TOUT)
`endif
    ) dut (.clk50mhz(clk), .reset_n(rst_n), .bus(bus), .ps2_clk_in(pad_clk), .ps2_dat_in(pad_dat),
           .ps2_clk_oe(clk_oe), .ps2_dat_oe(dat_oe));
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask
    function automatic logic [10:0] expect_frame(input logic [7:0] b);
        int ones = 0;
        for (int k = 0; k < 8; k++) ones += int'(b[k]);
        return {1'b1, (ones % 2 == 0), b, 1'b0};
    endfunction
    // model: busy from the accepting edge until the completion pulse, m_t = cycles since accept
    always @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            m_idle <= 1'b1;
            m_t <= 0;
        end else if ((m_idle || bus.tx_done || bus.tx_error) && bus.tx_valid) begin
            m_idle <= 1'b0;
            m_t <= 1;
        end else if (bus.tx_done || bus.tx_error) m_idle <= 1'b1;
        else if (!m_idle) m_t <= m_t + 1;
    always @(negedge clk) if (rst_n) begin
        if (bus.tx_done) n_done++;
        if (bus.tx_error) n_err++;
        if (bus.tx_done || bus.tx_error) begin
            chk("pulse_ready", bus.tx_ready, 1);
            chk("pulse_inhibit", bus.rx_inhibit, 0);
            chk("pulse_exclusive", bus.tx_done & bus.tx_error, 0);
        end else begin
            chk("ready", bus.tx_ready, m_idle);
            chk("rx_inhibit", bus.rx_inhibit, !m_idle);
        end
        if (m_idle) chk("idle_oe", {clk_oe, dat_oe}, 0);
        else if (m_t <= INH) chk("inhibit_oe", {clk_oe, dat_oe}, 2'b10);
        else if (m_t <= INH + REQ_C) chk("req_oe", {clk_oe, dat_oe}, 2'b11);
        else if (m_t == INH + REQ_C + 1) chk("start_bit_oe", {clk_oe, dat_oe}, 2'b01);
        else chk("send_clk_oe", clk_oe, 0);
    end
    task automatic start(input logic [7:0] b);
        @(negedge clk);
        bus.tx_data = b;
        bus.tx_valid = 1'b1;
    endtask
    task automatic dev_frame(input logic [7:0] b, input bit ack, input int stop_at, input int rst_at,
                             input bit glitchy, input bit next_v, input logic [7:0] next_b,
                             output logic [10:0] g);
        logic [10:0] exp;
        bit ok;
        int d0 = n_done, r0 = n_err;
        exp = expect_frame(b);
        g = '1;
        ok = 1'b0;
        for (int n = 0; n < 50 && !ok; n++) begin @(negedge clk); ok = !pad_clk; end
        chk("host_inhibit_seen", ok, 1);
        bus.tx_valid = 1'b0;
        ok = 1'b0;
        for (int n = 0; n < INH + REQ_C + 50 && !ok; n++) begin @(negedge clk); ok = pad_clk; end
        chk("host_clk_release", ok, 1);
        g[0] = pad_dat;
        for (int i = 1; i <= 11; i++) begin
            if (stop_at != 0 && i > stop_at) return;
            if (i == 11 && ack) dev_dat = 1'b0;
            if (glitchy && i >= 2 && i <= 10) begin
                repeat (H / 2) @(negedge clk);
                glitch = 1'b1;
                repeat (3) @(negedge clk);
                glitch = 1'b0;
                repeat (H - H / 2 - 3) @(negedge clk);
            end else repeat (H) @(negedge clk);
            dev_clk = 1'b0;
            last_fall = cyc;
            if (i == rst_at) begin
                repeat (30) @(negedge clk);
                chk("pre_reset_dat_oe", dat_oe, !exp[i]);
                #2 rst_n = 1'b0;
                #1 chk("async_reset_oe", {clk_oe, dat_oe}, 0);
                chk("async_reset_ready", {bus.tx_ready, bus.rx_inhibit}, 2'b10);
                dev_clk = 1'b1;
                repeat (3) begin
                    @(negedge clk);
                    chk("reset_no_pulse", {bus.tx_done, bus.tx_error}, 0);
                end
                rst_n = 1'b1;
                chk("reset_no_count", (n_done - d0) + (n_err - r0), 0);
                return;
            end
            if (i == 11 && next_v) begin
                bus.tx_data = next_b;
                bus.tx_valid = 1'b1;
                chk("held_while_busy", bus.tx_ready, 0);
            end
            repeat (H) @(negedge clk);
            if (i <= 10) g[i] = pad_dat;
            dev_clk = 1'b1;
        end
        dev_dat = 1'b1;
        chk("frame_bits", g, exp);
        if (ack) begin
            ok = 1'b0;
            for (int n = 0; n < 100 && !ok; n++) begin @(negedge clk); ok = (n_done != d0); end
            chk("done_seen", ok, 1);
        end else begin
            repeat (2) @(negedge clk);
            chk("nack_oe", {clk_oe, dat_oe}, 0);
            chk("nack_ready", bus.tx_ready, 1);
        end
        chk("done_count", n_done - d0, ack ? 1 : 0);
        chk("error_count", n_err - r0, ack ? 0 : 1);
    endtask
    initial begin
        bus.tx_valid = 1'b0;
        bus.tx_data = 8'h00;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ready", bus.tx_ready, 1);
        chk("rst_done", bus.tx_done, 0);
        chk("rst_error", bus.tx_error, 0);
        chk("rst_inhibit", bus.rx_inhibit, 0);
        chk("rst_clk_oe", clk_oe, 0);
        chk("rst_dat_oe", dat_oe, 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        start(8'hED);
        dev_frame(8'hED, 1, 0, 0, 0, 0, 8'h00, got);
        chk("lit_frame_ED", got, 11'h7DA);
        start(8'h01);
        dev_frame(8'h01, 1, 0, 0, 0, 1, 8'hFF, got);
        chk("lit_frame_01", got, 11'h402);
        dev_frame(8'hFF, 1, 0, 0, 0, 0, 8'h00, got);
        chk("lit_frame_FF", got, 11'h7FE);
        start(8'hF3);
        dev_frame(8'hF3, 0, 0, 0, 0, 0, 8'h00, got);
        chk("lit_frame_F3", got, 11'h7E6);
        start(8'hA5);
        dev_frame(8'hA5, 1, 0, 0, 1, 0, 8'h00, got);
        start(8'hED);
        dev_frame(8'hED, 1, 0, 5, 0, 0, 8'h00, got);
        repeat (10) @(negedge clk);
        start(8'h3C);
        dev_frame(8'h3C, 1, 0, 0, 0, 0, 8'h00, got);
        start(8'h55);
        e0 = n_err;
        dev_frame(8'h55, 1, 3, 0, 0, 0, 8'h00, got);
`ifdef PS2_HOST_TX_TIMEOUT_EN
        for (int n = 0; n < TOUT + 500 && n_err == e0; n++) @(negedge clk);
        chk("timeout_error", n_err - e0, 1);
        chk("timeout_delay", (cyc - last_fall >= TOUT) && (cyc - last_fall <= TOUT + 20), 1);
        @(negedge clk);
        chk("timeout_oe", {clk_oe, dat_oe}, 0);
        chk("timeout_ready", bus.tx_ready, 1);
`else
        repeat (TOUT + 500) @(negedge clk);
        chk("no_timeout_error", n_err - e0, 0);
        chk("hang_inhibit", bus.rx_inhibit, 1);
        chk("hang_ready", bus.tx_ready, 0);
        @(negedge clk) rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
`endif
        repeat (5) @(negedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
    initial begin
        #950000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end
endmodule
